rgmii_rx_ctrl: RTL

Receive-side controller for the RGMII PHY interface. It consumes the per-cycle outputs of the input DDR registers on the RX data and control pins and decodes RGMII in-band link status during idle. It selects the receive mode from the decoded speed and emits a GMII-style byte stream with a clock-enable strobe for the MAC. In 1000 mode it pairs the two edge samples into a byte every cycle; in 10/100 mode it assembles nibbles into bytes.

---
 rtl/rgmii_pkg.sv | 32 +++
 rtl/rgmii_inband_status.sv | 68 ++++++
 rtl/rgmii_rx_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared constants and types for the RGMII receive path: speed codes,
// in-band status word layout and the receive frame FSM states.
package rgmii_pkg;

    // Speed codes as carried in the in-band status word and on the speed port
    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;
    localparam logic [1:0] SPEED_RSVD = 2'b11;

    // Bit positions of the fields inside the idle status nibble
    localparam int ST_LINK_BIT   = 0;
    localparam int ST_SPEED_LSB  = 1;
    localparam int ST_SPEED_MSB  = 2;
    localparam int ST_DUPLEX_BIT = 3;

    // Status word, packed in the same order as it appears on RXD
    typedef struct packed {
        logic       duplex;
        logic [1:0] speed;
        logic       link;
    } status_t;

    // Receive frame FSM
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GIG,
        ST_LO,
        ST_HI
    } rx_state_e;

endpackage

// File: rtl/rgmii_inband_status.sv
// In-band status decoder: detects idle cycles, requires a run of identical
// valid status words before accepting one, and holds it as pending status.
module rgmii_inband_status
    import rgmii_pkg::*;
#(
    parameter int STATUS_STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rxd_q1,
    input  logic [3:0] rxd_q2,
    input  logic       rx_ctl_q1,
    input  logic       rx_ctl_q2,
    output logic       pending_valid,
    output logic       pending_link,
    output logic [1:0] pending_speed,
    output logic       pending_duplex
);

    localparam logic [7:0] STABLE = 8'(STATUS_STABLE_CYCLES);

    logic       idle;
    logic       word_ok;
    logic [3:0] word;
    logic [3:0] prev_word;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    status_t    pending;

    // Idle detect and run-length of identical valid status words
    always_comb begin
        word     = rxd_q1;
        idle     = !rx_ctl_q1 && !rx_ctl_q2 && (rxd_q1 == rxd_q2);
        word_ok  = idle && (word[ST_SPEED_MSB:ST_SPEED_LSB] != SPEED_RSVD);
        cnt_next = 8'd0;
        if (word_ok) begin
            // cnt == 0 means the previous sample broke the run, so restart at 1
            if (cnt != 8'd0 && word == prev_word)
                cnt_next = (cnt >= STABLE) ? cnt : cnt + 8'd1;
            else
                cnt_next = 8'd1;
        end
    end

    // Counter, last idle word and pending status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= 8'd0;
            prev_word     <= 4'h0;
            pending_valid <= 1'b0;
            pending       <= '0;
        end else begin
            cnt <= cnt_next;
            if (idle)
                prev_word <= word;
            // Saturated counter keeps reloading the same word, which is harmless
            if (cnt_next == STABLE) begin
                pending_valid <= 1'b1;
                pending       <= status_t'(word);
            end
        end
    end

    assign pending_link   = pending.link;
    assign pending_speed  = pending.speed;
    assign pending_duplex = pending.duplex;

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive controller: turns DDR-register samples into a GMII-style
// byte stream with a clock enable, and applies in-band link status between
// frames so the receive mode never changes inside a frame.
module rgmii_rx_ctrl
    import rgmii_pkg::*;
#(
    parameter int STATUS_STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rxd_q1,
    input  logic [3:0] rxd_q2,
    input  logic       rx_ctl_q1,
    input  logic       rx_ctl_q2,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_ce,
    output logic       link_up,
    output logic [1:0] speed,
    output logic       full_duplex,
    output logic       status_change
);

    logic       pending_valid;
    logic       pending_link;
    logic [1:0] pending_speed;
    logic       pending_duplex;

    rgmii_inband_status #(
        .STATUS_STABLE_CYCLES(STATUS_STABLE_CYCLES)
    ) u_status (
        .clk           (clk),
        .rst           (rst),
        .rxd_q1        (rxd_q1),
        .rxd_q2        (rxd_q2),
        .rx_ctl_q1     (rx_ctl_q1),
        .rx_ctl_q2     (rx_ctl_q2),
        .pending_valid (pending_valid),
        .pending_link  (pending_link),
        .pending_speed (pending_speed),
        .pending_duplex(pending_duplex)
    );

    rx_state_e  state;
    rx_state_e  state_next;
    logic [3:0] low_nib;
    logic [3:0] low_nib_next;
    logic       low_er;
    logic       low_er_next;
    logic [7:0] rxd_next;
    logic       dv_next;
    logic       er_next;
    logic       ce_next;
    logic       dv;
    logic       er;
    logic       apply;
    logic       change;

    assign dv = rx_ctl_q1;
    assign er = rx_ctl_q1 ^ rx_ctl_q2;

    // Frame FSM next state and next GMII outputs
    always_comb begin
        state_next   = state;
        low_nib_next = low_nib;
        low_er_next  = low_er;
        rxd_next     = 8'h00;
        dv_next      = 1'b0;
        er_next      = 1'b0;
        ce_next      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dv) begin
                    // The first dv sample already carries data, so it is
                    // handled here exactly as GIG/LO would handle it
                    if (speed == SPEED_1000) begin
                        state_next = ST_GIG;
                        rxd_next   = {rxd_q2, rxd_q1};
                        dv_next    = 1'b1;
                        er_next    = er;
                        ce_next    = 1'b1;
                    end else begin
                        state_next   = ST_HI;
                        low_nib_next = rxd_q1;
                        low_er_next  = er;
                    end
                end else if (er) begin
                    // False carrier indication
                    rxd_next = {rxd_q2, rxd_q1};
                    er_next  = 1'b1;
                    ce_next  = 1'b1;
                end
            end
            ST_GIG: begin
                if (dv) begin
                    rxd_next = {rxd_q2, rxd_q1};
                    dv_next  = 1'b1;
                    er_next  = er;
                    ce_next  = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LO: begin
                if (dv) begin
                    state_next   = ST_HI;
                    low_nib_next = rxd_q1;
                    low_er_next  = er;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HI: begin
                dv_next = 1'b1;
                ce_next = 1'b1;
                if (dv) begin
                    state_next = ST_LO;
                    rxd_next   = {rxd_q1, low_nib};
                    er_next    = low_er | er;
                end else begin
                    // Frame ended on an odd nibble: flush it flagged as error
                    state_next = ST_IDLE;
                    rxd_next   = {4'h0, low_nib};
                    er_next    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame FSM state and held low nibble
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            low_nib <= 4'h0;
            low_er  <= 1'b0;
        end else begin
            state   <= state_next;
            low_nib <= low_nib_next;
            low_er  <= low_er_next;
        end
    end

    // Registered GMII outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            gmii_rxd   <= 8'h00;
            gmii_rx_dv <= 1'b0;
            gmii_rx_er <= 1'b0;
            gmii_rx_ce <= 1'b0;
        end else begin
            gmii_rxd   <= rxd_next;
            gmii_rx_dv <= dv_next;
            gmii_rx_er <= er_next;
            gmii_rx_ce <= ce_next;
        end
    end

    // Status only moves while idle and no frame is starting this cycle
    assign apply  = pending_valid && (state == ST_IDLE) && !dv;
    assign change = apply &&
                    ({pending_duplex, pending_speed, pending_link} !=
                     {full_duplex, speed, link_up});

    // Applied link status and change pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            link_up       <= 1'b0;
            speed         <= SPEED_10;
            full_duplex   <= 1'b0;
            status_change <= 1'b0;
        end else begin
            status_change <= change;
            if (apply) begin
                link_up     <= pending_link;
                speed       <= pending_speed;
                full_duplex <= pending_duplex;
            end
        end
    end

endmodule
